// File: rtl/instmem_arbiter_pkg.sv
// rtl/instmem_arbiter_pkg.sv - shared types and defaults for the instmem arbiter
package instmem_arbiter_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_LD = 1'b1
    } owner_t;

endpackage

// File: rtl/instmem_arbiter_rr_arb2.sv
// rtl/instmem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import instmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     ptr,
    output logic [1:0] grant,
    output logic       valid
);

    // On contention the pointer names the side that wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr == OWN_LD) ? 2'b10 : 2'b01;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/instmem_arbiter.sv
// rtl/instmem_arbiter.sv - sequences icache refill and loader accesses onto the instmem block port
module instmem_arbiter
    import instmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WORD_SIZE,
    parameter int BLOCK_W = BLOCK_SIZE,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic               ic_done,
    output logic [BLOCK_W-1:0] ic_rdata,
    output logic               ic_inval,
    output logic [ADDR_W-1:0]  ic_inval_addr,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [BLOCK_W-1:0] ld_wdata,
    output logic               ld_done,
    output logic [BLOCK_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_readable,
    output logic               mem_writable,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               busy
);

    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_t         state, state_nxt;
    owner_t             ptr, owner_q, grant_owner;
    logic [CW-1:0]      cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [1:0]         grant;
    logic               grant_valid;

    rr_arb2 u_rr_arb2 (
        .req   ({ld_req, ic_req}),
        .ptr   (ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_owner = (grant == 2'b10) ? OWN_LD : OWN_IC;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        mem_readable  = 1'b0;
        mem_writable  = 1'b0;
        ic_done       = 1'b0;
        ld_done       = 1'b0;
        ic_inval      = 1'b0;
        ic_inval_addr = '0;
        busy          = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                busy         = 1'b1;
                mem_readable = ~we_q;
                mem_writable = we_q;
                if (cnt == '0) begin
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                busy    = 1'b1;
                ic_done = (owner_q == OWN_IC);
                ld_done = (owner_q == OWN_LD);
                // Loader writes may overwrite lines the icache already holds.
                if (owner_q == OWN_LD && we_q) begin
                    ic_inval      = 1'b1;
                    ic_inval_addr = addr_q;
                end
                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= OWN_IC;
            owner_q  <= OWN_IC;
            cnt      <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ic_rdata <= '0;
            ld_rdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        cnt     <= CW'(MEM_LAT - 1);
                        if (grant_owner == OWN_LD) begin
                            addr_q  <= ld_addr;
                            we_q    <= ld_we;
                            wdata_q <= ld_wdata;
                        end else begin
                            addr_q <= ic_addr;
                            we_q   <= 1'b0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            if (owner_q == OWN_IC) begin
                                ic_rdata <= mem_rdata;
                            end else begin
                                ld_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_DONE: begin
                    ptr <= (owner_q == OWN_IC) ? OWN_LD : OWN_IC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instmem_arbiter.sv
// tb/tb_instmem_arbiter.sv - scoreboard bench for instmem_arbiter
module tb_instmem_arbiter;

    localparam int AW  = 32;
    localparam int BW  = 1024;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req, ic_done, ic_inval;
    logic [AW-1:0] ic_addr, ic_inval_addr;
    logic [BW-1:0] ic_rdata;
    logic          ld_req, ld_we, ld_done;
    logic [AW-1:0] ld_addr;
    logic [BW-1:0] ld_wdata, ld_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_readable, mem_writable, busy;
    logic [BW-1:0] mem_wdata, mem_rdata;

    logic          tb_init = 1'b1;
    logic [BW-1:0] mem [0:15];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        bit            ld;
        int            cyc;
        logic [BW-1:0] data;
        bit            inval;
        logic [AW-1:0] iaddr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    instmem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_done       (ic_done),
        .ic_rdata      (ic_rdata),
        .ic_inval      (ic_inval),
        .ic_inval_addr (ic_inval_addr),
        .ld_req        (ld_req),
        .ld_we         (ld_we),
        .ld_addr       (ld_addr),
        .ld_wdata      (ld_wdata),
        .ld_done       (ld_done),
        .ld_rdata      (ld_rdata),
        .mem_addr      (mem_addr),
        .mem_readable  (mem_readable),
        .mem_writable  (mem_writable),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instmem model: combinational read, write on the edge while writable.
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[4] <= 1024'h5A;
            mem[5] <= 1024'hC3;
            mem[7] <= 1024'h77;
        end else if (mem_writable) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got lo64 %0h expected lo64 %0h (cycle %0d)", name, act[63:0], exp[63:0], cyc);
        end
    endtask

    task automatic push(bit ld, int c, logic [BW-1:0] d, bit inv, logic [AW-1:0] ia);
        exp_t e;
        e.ld = ld; e.cyc = c; e.data = d; e.inval = inv; e.iaddr = ia;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic chk_access(string nm, bit rd, logic [AW-1:0] a);
        @(negedge clk);
        chk({nm, "_strobes"}, {mem_readable, mem_writable}, rd ? 2'b10 : 2'b01);
        chk({nm, "_addr"}, mem_addr, a);
    endtask

    // Monitor: every done pulse is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && !tb_init) begin
            if (ic_done || ld_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got ic=%0b ld=%0b expected none (cycle %0d)", ic_done, ld_done, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_owner", ld_done, mon_e.ld);
                    chk("done_both", ic_done & ld_done, 0);
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk_blk("done_rdata", mon_e.ld ? ld_rdata : ic_rdata, mon_e.data);
                    chk("done_inval", ic_inval, mon_e.inval);
                    if (mon_e.inval) chk("done_inval_addr", ic_inval_addr, mon_e.iaddr);
                end
            end else if (ic_inval) begin
                checks++;
                errors++;
                $display("FAIL spurious_inval: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, mem_readable, mem_writable, ic_done, ld_done, ic_inval}, 0);
        chk("rst_addrs", {mem_addr, ic_inval_addr}, 0);
        @(posedge clk);
        #1;
        tb_init = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {busy, mem_readable, mem_writable, ic_done, ld_done, ic_inval}, 0);
            chk_blk("idle_ic_rdata", ic_rdata, '0);
            chk_blk("idle_ld_rdata", ld_rdata, '0);
            tick();
        end

        // Simultaneous after reset: icache preferred, loader next.
        t0 = cyc;
        ic_req = 1'b1; ic_addr = 4;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 7;
        push(0, t0 + 3, 1024'h5A, 0, 0);
        push(1, t0 + 7, 1024'h77, 0, 0);
        @(negedge clk);
        chk("b_idle", {mem_readable, mem_writable, busy}, 0);
        tick(); chk_access("b_ic1", 1, 4);
        tick(); chk_access("b_ic2", 1, 4);
        ticks(2); ic_req = 1'b0;
        tick(); chk_access("b_ld1", 1, 7);
        ticks(3); ld_req = 1'b0;
        ticks(2);

        // Lone icache read moves the pointer to the loader.
        t0 = cyc;
        ic_req = 1'b1; ic_addr = 5;
        push(0, t0 + 3, 1024'hC3, 0, 0);
        ticks(4); ic_req = 1'b0;
        ticks(2);
        @(negedge clk);
        chk_blk("c_ic_rdata_held", ic_rdata, 1024'hC3);
        tick();

        // Simultaneous again: loader now wins.
        t0 = cyc;
        ic_req = 1'b1; ic_addr = 4;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 7;
        push(1, t0 + 3, 1024'h77, 0, 0);
        push(0, t0 + 7, 1024'h5A, 0, 0);
        tick(); chk_access("d_ld1", 1, 7);
        ticks(3); ld_req = 1'b0;
        ticks(4); ic_req = 1'b0;
        ticks(2);

        // Loader write: invalidate pulse, ld_rdata untouched, late input changes ignored.
        t0 = cyc;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9; ld_wdata = 1024'h3;
        push(1, t0 + 3, 1024'h77, 1, 9);
        tick(); chk_access("e_wr1", 0, 9);
        chk_blk("e_wdata1", mem_wdata, 1024'h3);
        ld_addr = 2; ld_wdata = 1024'h5;
        tick(); chk_access("e_wr2", 0, 9);
        chk_blk("e_wdata2", mem_wdata, 1024'h3);
        ticks(2); ld_req = 1'b0; ld_we = 1'b0;
        ticks(2);

        // Reset during the second access cycle of an icache read.
        t0 = cyc;
        ic_req = 1'b1; ic_addr = 4;
        ticks(2);
        @(negedge clk);
        chk("f_pre_rst_rd", mem_readable, 1);
        rst = 1'b1;
        #1;
        chk("f_rst_outs", {mem_readable, mem_writable, busy, ic_done}, 0);
        chk_blk("f_rst_ic_rdata", ic_rdata, '0);
        chk_blk("f_rst_ld_rdata", ld_rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
        push(0, t0 + 3, 1024'h5A, 0, 0);
        ticks(4); ic_req = 1'b0;
        ticks(2);

        // Loader streaming reads of the written block; icache joins mid-stream.
        t0 = cyc;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9;
        ic_addr = 5;
        push(1, t0 + 3, 1024'h3, 0, 0);
        push(1, t0 + 7, 1024'h3, 0, 0);
        push(0, t0 + 11, 1024'hC3, 0, 0);
        push(1, t0 + 15, 1024'h3, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 5)  ic_req = 1'b1;
            if (k == 12) ic_req = 1'b0;
            if (k == 16) ld_req = 1'b0;
        end
        ticks(3);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
